// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock divider: run enable,
// divisor load handshake, and the divided-clock outputs.
interface clk_div_prog_if #(
   parameter int DIV_W = 8
);
   logic             en;
   logic [DIV_W-1:0] div_val;
   logic             div_load;
   logic             div_ack;
   logic             div_err;
   logic             busy;
   logic             out_clk;
   logic             tick;

   modport master (
      output en, div_val, div_load,
      input  div_ack, div_err, busy, out_clk, tick
   );

   modport slave (
      input  en, div_val, div_load,
      output div_ack, div_err, busy, out_clk, tick
   );
endinterface

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider: glitch-free divided clock with a tick per
// period; new divisors are staged and only applied at a period boundary.
module clk_div_prog #(
   parameter int DIV_W     = 8,
   parameter int DIV_RESET = 4
) (
   input logic           clk,
   input logic           reset,
   clk_div_prog_if.slave bus
);

   if (DIV_RESET < 2 || DIV_RESET > (2 ** DIV_W) - 1) begin : g_bad_div_reset
      $error("clk_div_prog: DIV_RESET must lie in 2..2**DIV_W-1");
   end

   localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DIV_RESET);

   logic [DIV_W-1:0] cur_div;
   logic [DIV_W-1:0] pend_div;
   logic [DIV_W-1:0] cnt;
   logic             pend_valid;
   logic             out_clk_q;
   logic             tick_q;
   logic             ack_q;
   logic             err_q;

   logic [DIV_W-1:0] hi;
   logic             at_wrap;
   logic             apply;
   logic             load_ok;

   always_comb begin
      hi      = cur_div - (cur_div >> 1);
      at_wrap = (cnt == cur_div - DIV_W'(1));
      // A pending divisor goes live at the end of a period, or at once while idle.
      apply   = pend_valid && (!bus.en || at_wrap);
      load_ok = bus.div_load && (bus.div_val >= DIV_W'(2));
   end

   // NOTE: async reset clears every register here; pend_div is cleared too so
   // no stale divisor can survive a reset even though pend_valid guards it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_div    <= RST_DIV;
         pend_div   <= '0;
         pend_valid <= 1'b0;
         cnt        <= '0;
         out_clk_q  <= 1'b0;
         tick_q     <= 1'b0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         ack_q <= apply;
         err_q <= bus.div_load && !load_ok;

         if (bus.en) begin
            out_clk_q <= (cnt < hi);
            tick_q    <= (cnt == '0);
            cnt       <= at_wrap ? '0 : cnt + DIV_W'(1);
         end else begin
            out_clk_q <= 1'b0;
            tick_q    <= 1'b0;
            cnt       <= '0;
         end

         // NOTE: non-blocking updates mean the apply below reads the old
         // pend_div, while a same-edge load overwrites it and keeps it pending.
         if (apply) begin
            cur_div    <= pend_div;
            pend_valid <= 1'b0;
         end
         if (load_ok) begin
            pend_div   <= bus.div_val;
            pend_valid <= 1'b1;
         end
      end
   end

   assign bus.out_clk = out_clk_q;
   assign bus.tick    = tick_q;
   assign bus.div_ack = ack_q;
   assign bus.div_err = err_q;
   assign bus.busy    = pend_valid;

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Programmable integer clock divider: the parametrised successor to the fixed divide-by-4 divider. It produces a divided clock-enable waveform `out_clk` with a runtime-selectable ratio N (2..2^DIV_W-1), plus a one-cycle `tick` pulse per output period. A new ratio is accepted through a load/ack handshake and takes effect only at a period boundary, so the output never glitches. It sits beside the system clock generator and feeds slow-peripheral timing (UART baud, LED scan, sampling strobes).

## Interface
- `DIV_W`, default 8: width of divisor and internal counter.
- `DIV_RESET`, default 4: divisor active after reset; must be ≥2 and ≤2^DIV_W-1 (elaboration-time check).

Ports:
- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `en` input 1: run enable; 0 holds the divider idle.
- `div_val` input DIV_W: requested divisor N.
- `div_load` input 1: one-cycle strobe; captures `div_val`.
- `div_ack` output 1: one-cycle pulse when a pending divisor becomes active.
- `div_err` output 1: one-cycle pulse when a load is rejected (N<2).
- `busy` output 1: a captured divisor is pending, not yet applied.
- `out_clk` output 1: divided clock, registered.
- `tick` output 1: one-cycle pulse on the first high cycle of each `out_clk` period.

## Operation
- State: `cur_div` (active N), `pend_div`, `pend_valid`, `cnt` (DIV_W bits, 0..cur_div-1).
- Reset values: `cur_div`=DIV_RESET, `cnt`=0, `pend_valid`=0; outputs `out_clk`, `tick`, `div_ack`, `div_err`, `busy` all 0.
- High-phase length `hi` = cur_div - (cur_div>>1), i.e. ceil(N/2); low phase = floor(N/2).
- Enabled edge (`en`=1): `out_clk` <= (cnt < hi); `tick` <= (cnt==0); `cnt` <= (cnt==cur_div-1) ? 0 : cnt+1.
- Disabled edge (`en`=0): `cnt` <= 0, `out_clk` <= 0, `tick` <= 0. Dropping `en` mid-period truncates the current phase; re-enabling restarts a full period with the high phase first.
- Load: `div_load`=1 with `div_val`≥2 -> `pend_div` <= div_val, `pend_valid` <= 1. Last load wins if multiple loads arrive before apply.
- Reject: `div_load`=1 with `div_val`<2 -> `div_err`=1 next cycle; `pend_div`/`pend_valid` unchanged.
- Apply: on an enabled edge with cnt==cur_div-1 and `pend_valid`=1 -> `cur_div` <= pend_div, `cnt` <= 0, `pend_valid` <= 0, `div_ack` <= 1. `out_clk` on that edge is still computed from the old `cnt`/`hi`.
- Apply while disabled: on any `en`=0 edge with `pend_valid`=1, apply immediately (same register updates, `div_ack` pulses).
- Simultaneous `div_load` and apply edge: the previously pending value is applied; the new value is captured and stays pending (`pend_valid` remains 1, `busy` stays 1).
- `busy` = registered `pend_valid`.
- Reset asserted mid-operation: all state returns to reset values asynchronously; a pending divisor is discarded without `div_ack`.

## Timing
- All outputs registered; no combinational input-to-output paths.
- First `out_clk` high / `tick`: on the 1st enabled edge after reset release, or after `en` rises.
- `out_clk` period = cur_div cycles: high ceil(N/2) cycles, then low floor(N/2) cycles. Duty is exactly 50% for even N; high is one cycle longer for odd N.
- Load-to-apply latency: at most cur_div cycles while enabled; 1 cycle while disabled. The new N governs the period starting on the edge after `div_ack`.
- `div_err`: 1 cycle after the rejected strobe.

## Test plan
- Reset release, `en`=1, DIV_RESET=4 -> `out_clk` 1,1,0,0 repeating; `tick` high every 4th cycle, aligned with the first high cycle; all outputs 0 during reset.
- Load N=5 mid-period while running N=4 -> `busy`=1 until the wrap edge; `div_ack` pulses at the wrap; the next period is high 3 cycles, low 2 cycles.
- Load N=1, then N=0 -> `div_err` pulses each time; `cur_div` stays 4; `busy` stays 0.
- Load N=6 then N=3 before the boundary -> a single `div_ack`; period becomes 3 (high 2, low 1); 6 is never applied.
- Drop `en` during the high phase, load N=2, raise `en` -> `out_clk`=0 on the disabled edge; `div_ack` on the next disabled edge; restart 1,0,1,0.
- Assert `reset` asynchronously mid-cycle with a load pending -> outputs go to 0 immediately with no `div_ack`; after release the divider runs at N=4.
